// File: rtl/cube_input_ctrl.sv
// Cube colour-entry controller: 54-facelet store, cursor/face editing, valid/ready state dump.
// Optional cursor blink divider is built only when CURSOR_BLINK_EN is defined.
module cube_input_ctrl #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic        btn_face,
  input  logic        dump_req,
  output logic [2:0]  face_idx,
  output logic [1:0]  cursor_row,
  output logic [1:0]  cursor_col,
  output logic        cursor_blink,
  output logic [26:0] face_colours,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [2:0]  dump_data,
  output logic        dump_last,
  output logic        busy
);

  // Dump stream: a beat transfers on a rising edge where dump_valid && dump_ready;
  // dump_data/dump_last are a pure function of the beat index, so they hold while stalled.

  typedef enum logic {EDIT = 1'b0, DUMP = 1'b1} stateT;

  stateT      state, stateNext;
  logic [2:0] cells [54];
  logic [2:0] faceIdx;
  logic [1:0] curRow, curCol;
  logic [5:0] dumpIdx;
  logic [5:0] editIdx, faceBase;
  logic       doSelect, doFace, doUp, doDown, doLeft, doRight, beatDone;

  always_ff @(posedge clock) begin
    if (reset) state <= EDIT;
    else       state <= stateNext;
  end

  // One action per cycle; a select on the centre still wins priority but does nothing.
  always_comb begin
    stateNext = state;
    doSelect  = 1'b0;
    doFace    = 1'b0;
    doUp      = 1'b0;
    doDown    = 1'b0;
    doLeft    = 1'b0;
    doRight   = 1'b0;
    beatDone  = 1'b0;
    case (state)
      EDIT: begin
        if (dump_req)        stateNext = DUMP;
        else if (btn_select) doSelect  = !(curRow == 2'd1 && curCol == 2'd1);
        else if (btn_face)   doFace    = 1'b1;
        else if (btn_up)     doUp      = 1'b1;
        else if (btn_down)   doDown    = 1'b1;
        else if (btn_left)   doLeft    = 1'b1;
        else if (btn_right)  doRight   = 1'b1;
      end
      DUMP: begin
        beatDone = dump_ready;
        if (dump_ready && dumpIdx == 6'd53) stateNext = EDIT;
      end
      default: stateNext = EDIT;
    endcase
  end

  assign faceBase = 6'(faceIdx) * 6'd9;
  assign editIdx  = faceBase + 6'(curRow) * 6'd3 + 6'(curCol);

  always_ff @(posedge clock) begin
    if (reset) begin
      faceIdx <= 3'd0;
      curRow  <= 2'd0;
      curCol  <= 2'd0;
      dumpIdx <= 6'd0;
      for (int i = 0; i < 54; i++) cells[i] <= 3'(i / 9 + 1);
    end else begin
      if (doSelect)
        cells[editIdx] <= (cells[editIdx] == 3'd6) ? 3'd1 : cells[editIdx] + 3'd1;
      if (doFace)  faceIdx <= (faceIdx == 3'd5) ? 3'd0 : faceIdx + 3'd1;
      if (doUp)    curRow  <= (curRow == 2'd0) ? 2'd2 : curRow - 2'd1;
      if (doDown)  curRow  <= (curRow == 2'd2) ? 2'd0 : curRow + 2'd1;
      if (doLeft)  curCol  <= (curCol == 2'd0) ? 2'd2 : curCol - 2'd1;
      if (doRight) curCol  <= (curCol == 2'd2) ? 2'd0 : curCol + 2'd1;
      if (state == EDIT)  dumpIdx <= 6'd0;
      else if (beatDone)  dumpIdx <= (dumpIdx == 6'd53) ? 6'd0 : dumpIdx + 6'd1;
    end
  end

  always_comb begin
    face_colours = '0;
    for (int k = 0; k < 9; k++) face_colours[3*k +: 3] = cells[faceBase + 6'(k)];
  end

  assign face_idx   = faceIdx;
  assign cursor_row = curRow;
  assign cursor_col = curCol;
  assign busy       = (state == DUMP);
  assign dump_valid = (state == DUMP);
  assign dump_data  = (state == DUMP) ? cells[dumpIdx] : 3'd0;
  assign dump_last  = (state == DUMP) && (dumpIdx == 6'd53);

`ifdef CURSOR_BLINK_EN
  localparam int CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CntW-1:0] blinkCnt;
  logic            blinkOn;

  // Any cursor/face movement restarts the period with the highlight on.
  always_ff @(posedge clock) begin
    if (reset || state == DUMP || doFace || doUp || doDown || doLeft || doRight) begin
      blinkCnt <= '0;
      blinkOn  <= 1'b1;
    end else if (blinkCnt == CntW'(BLINK_DIV - 1)) begin
      blinkCnt <= '0;
      blinkOn  <= ~blinkOn;
    end else begin
      blinkCnt <= blinkCnt + 1'b1;
    end
  end

  assign cursor_blink = blinkOn;
`else
  // Steady highlight; the divider parameter is kept in the interface for the blink build.
  assign cursor_blink = 1'b1 | (BLINK_DIV == 0);
`endif

endmodule

// File: tb/tb_cube_input_ctrl.sv
// Directed self-checking bench for cube_input_ctrl (editing, priority, dump stream, reset abort, blink).
module tb_cube_input_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_select, btn_face, dump_req;
  logic [2:0]  face_idx;
  logic [1:0]  cursor_row, cursor_col;
  logic        cursor_blink;
  logic [26:0] face_colours;
  logic        dump_valid, dump_ready, dump_last, busy;
  logic [2:0]  dump_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_cells [54];

  localparam logic [6:0] B_DUMP = 7'b1000000, B_SEL = 7'b0100000, B_FACE = 7'b0010000,
                         B_UP = 7'b0001000, B_DOWN = 7'b0000100, B_LEFT = 7'b0000010,
                         B_RIGHT = 7'b0000001;

  cube_input_ctrl #(.BLINK_DIV(4)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_select(btn_select), .btn_face(btn_face), .dump_req(dump_req),
    .face_idx(face_idx), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cursor_blink(cursor_blink), .face_colours(face_colours),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_last(dump_last), .busy(busy)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_btns(input logic [6:0] b);
    {dump_req, btn_select, btn_face, btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  // drive one cycle of button pulses, then release
  task automatic press(input logic [6:0] b);
    set_btns(b);
    tick();
    set_btns(7'd0);
  endtask

  task automatic do_reset();
    set_btns(7'd0);
    dump_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 54; i++) exp_cells[i] = 3'(i / 9 + 1);
  endtask

  function automatic logic [26:0] exp_face(input int f);
    logic [26:0] v = '0;
    for (int k = 0; k < 9; k++) v[3*k +: 3] = exp_cells[9*f + k];
    return v;
  endfunction

  // full dump with ready held high: 54 back-to-back beats
  task automatic dump_full(input string tag);
    dump_ready = 1'b1;
    press(B_DUMP);
    check({tag, " busy"}, busy, 1);
    for (int b = 0; b < 54; b++) begin
      check({tag, " valid"}, dump_valid, 1);
      check({tag, " data"}, dump_data, exp_cells[b]);
      check({tag, " last"}, dump_last, (b == 53));
      tick();
    end
    check({tag, " end valid"}, dump_valid, 0);
    check({tag, " end busy"}, busy, 0);
    dump_ready = 1'b0;
  endtask

  initial begin
    int idx, cyc;
    logic prev_stall;
    logic [2:0] prev_data;

    set_btns(7'd0);
    dump_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    do_reset();

    // 1. reset state and solved dump
    check("rst face", face_idx, 0);
    check("rst row", cursor_row, 0);
    check("rst col", cursor_col, 0);
    check("rst blink", cursor_blink, 1);
    check("rst valid", dump_valid, 0);
    check("rst last", dump_last, 0);
    check("rst data", dump_data, 0);
    check("rst busy", busy, 0);
    check("rst colours", face_colours, 27'o111111111);
    dump_full("solved dump");

    // 2. cursor wrap and priority
    press(B_UP);
    check("up row", cursor_row, 2);
    check("up col", cursor_col, 0);
    press(B_LEFT);
    check("left col", cursor_col, 2);
    press(B_RIGHT);
    check("right col", cursor_col, 0);
    press(B_UP | B_SEL);
    check("prio row", cursor_row, 2);
    check("prio col", cursor_col, 0);
    check("prio colour", face_colours[18 +: 3], 2);
    press(B_DOWN);
    check("down wrap row", cursor_row, 0);

    // 3. colour cycling at (0,0), centre fixed
    do_reset();
    begin
      logic [2:0] seq [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
      for (int i = 0; i < 6; i++) begin
        press(B_SEL);
        check("cycle colour", face_colours[2:0], seq[i]);
      end
    end
    press(B_DOWN);
    press(B_RIGHT);
    check("centre pos", {cursor_row, cursor_col}, 4'b0101);
    press(B_SEL);
    check("centre fixed", face_colours, 27'o111111111);

    // 4. edit then walk all faces
    do_reset();
    press(B_SEL);
    press(B_SEL);
    exp_cells[0] = 3'd3;
    for (int f = 1; f <= 6; f++) begin
      press(B_FACE);
      check("face idx", face_idx, f % 6);
      check("face colours", face_colours, exp_face(f % 6));
    end
    check("edit kept", face_colours[2:0], 3);
    dump_full("edited dump");

    // 5. stalled dump, select ignored, then reset abort
    do_reset();
    press(B_DUMP);
    idx = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = 3'd0;
    while (idx < 54 && cyc < 400) begin
      dump_ready = cyc[0];
      btn_select = (cyc == 5);
      check("stall valid", dump_valid, 1);
      check("stall busy", busy, 1);
      check("stall data", dump_data, exp_cells[idx]);
      check("stall last", dump_last, (idx == 53));
      if (prev_stall) check("stall hold", dump_data, prev_data);
      prev_stall = !dump_ready;
      prev_data = dump_data;
      if (dump_ready) idx++;
      tick();
      cyc++;
    end
    btn_select = 1'b0;
    dump_ready = 1'b0;
    check("stall beats", idx, 54);
    check("stall busy fall", busy, 0);
    check("stall valid fall", dump_valid, 0);
    check("dump select ignored", face_colours, 27'o111111111);

    press(B_SEL);
    check("pre abort edit", face_colours[2:0], 2);
    dump_ready = 1'b1;
    press(B_DUMP);
    for (int b = 0; b < 20; b++) tick();
    check("abort beat20 data", dump_data, exp_cells[20]);
    dump_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("abort valid", dump_valid, 0);
    check("abort busy", busy, 0);
    reset = 1'b0;
    tick();
    check("abort solved", face_colours, 27'o111111111);

    // 6. cursor blink
    do_reset();
`ifdef CURSOR_BLINK_EN
    begin
      logic exp_blink [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      // edges 1..12 after reset; btn_right applied on edge 7
      for (int k = 0; k < 12; k++) begin
        if (k == 6) press(B_RIGHT);
        else        tick();
        check("blink", cursor_blink, exp_blink[k]);
      end
    end
`else
    for (int k = 0; k < 10; k++) begin
      if (k == 6) press(B_RIGHT);
      else        tick();
      check("blink steady", cursor_blink, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
